// File: rtl/axi_sync_ctrl.sv
// axi_sync_ctrl: lock-step release of SIZE AXI-Stream ports with
// misalignment flush. Optional stall watchdog: AXI_SYNC_CTRL_WATCHDOG_EN.
module axi_sync_ctrl #(
  parameter int SIZE    = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [SIZE*WIDTH-1:0] i_tdata,
  input  logic [SIZE-1:0]       i_tlast,
  input  logic [SIZE-1:0]       i_tvalid,
  output logic [SIZE-1:0]       i_tready,
  output logic [SIZE*WIDTH-1:0] o_tdata,
  output logic [SIZE-1:0]       o_tlast,
  output logic [SIZE-1:0]       o_tvalid,
  input  logic [SIZE-1:0]       o_tready,
  output logic [CNT_W-1:0]      misalign_cnt,
  output logic                  stall
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SIZE-1:0]  r_done;
  logic [SIZE-1:0]  w_done_nxt;
  logic [SIZE-1:0]  w_flush_acc;
  logic [CNT_W-1:0] r_mis_cnt;
  logic             w_rst;
  logic             w_run;
  logic             w_all_v;
  logic             w_all_r;
  logic             w_match;
  logic             w_release;
  logic             w_misalign;

  assign w_rst   = reset | clear;
  assign w_run   = (r_state == S_RUN);
  assign w_all_v = &i_tvalid;
  assign w_all_r = &o_tready;
  // A single port always matches itself, so FLUSH is never entered.
  assign w_match = (~|i_tlast) | (&i_tlast);

  assign w_release  = w_all_v & w_all_r & w_match;
  assign w_misalign = w_run & w_all_v & ~w_match;

  // Data and framing are wires; only the handshakes are gated.
  assign o_tdata = i_tdata;
  assign o_tlast = i_tlast;

  // Done flags as they will be after this cycle's flush acceptances.
  assign w_flush_acc = i_tvalid & ~r_done;
  assign w_done_nxt  = r_done | (w_flush_acc & i_tlast);

  assign misalign_cnt = r_mis_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave FLUSH once every port has seen its packet end.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (w_misalign) w_state_nxt = S_FLUSH;
      S_FLUSH: if (&w_done_nxt) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Handshake outputs; both forced low during reset/clear.
  always_comb begin
    o_tvalid = '0;
    i_tready = '0;
    if (!w_rst) begin
      unique case (r_state)
        S_RUN: begin
          o_tvalid = {SIZE{w_release}};
          i_tready = {SIZE{w_release}};
        end
        S_FLUSH: i_tready = ~r_done;
        default: ;
      endcase
    end
  end

  // Per-port end-of-packet flags, cleared on flush entry.
  always_ff @(posedge clk) begin
    if (w_rst || w_misalign) begin
      r_done <= '0;
    end else if (r_state == S_FLUSH) begin
      r_done <= w_done_nxt;
    end
  end

  // Saturating misalignment counter.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_mis_cnt <= '0;
    end else if (w_misalign && (r_mis_cnt != '1)) begin
      r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("axi_sync_ctrl: TIMEOUT must be >= 2");
  end

`ifdef AXI_SYNC_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_stall;
  logic            w_wd_inc;

  // Only a partial set of valids counts; backpressure does not.
  assign w_wd_inc = w_run & (|i_tvalid) & ~w_all_v;
  assign stall    = r_stall;

  // Watchdog counter (held at TIMEOUT) and sticky stall flag.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_wd    <= '0;
      r_stall <= 1'b0;
    end else if (w_wd_inc) begin
      if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
      if (r_wd == WD_LAST) r_stall <= 1'b1;
    end else begin
      r_wd <= '0;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_axi_sync_ctrl.sv
// tb_axi_sync_ctrl: directed + randomized packet traffic for
// axi_sync_ctrl, scored against a packet-level model.
module tb_axi_sync_ctrl;

  localparam int SIZE = 2;
  localparam int W    = 8;
  localparam int TO   = 16;
  localparam int CW   = 4;
`ifdef AXI_SYNC_CTRL_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clear = 1'b0;
  logic [SIZE*W-1:0] i_tdata = '0;
  logic [SIZE-1:0] i_tlast = '0;
  logic [SIZE-1:0] i_tvalid = '0;
  logic [SIZE-1:0] i_tready;
  logic [SIZE*W-1:0] o_tdata;
  logic [SIZE-1:0] o_tlast;
  logic [SIZE-1:0] o_tvalid;
  logic [SIZE-1:0] o_tready = '0;
  logic [CW-1:0]   misalign_cnt;
  logic            stall;

  axi_sync_ctrl #(
    .SIZE(SIZE), .WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready),
    .misalign_cnt(misalign_cnt), .stall(stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mis_total = 0;
  int nout = 0;

  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  logic [16:0] expq[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
    return (mis_total > 15) ? 32'd15 : 32'(mis_total);
  endfunction

  // One packet on each port. Equal lengths pass whole; unequal
  // lengths pass the common non-last prefix, then both are dropped.
  task automatic add_pair(input int len0, input int len1);
    logic [7:0] b0[8];
    logic [7:0] b1[8];
    int n;
    n = (len0 < len1) ? len0 : len1;
    for (int i = 0; i < len0; i++) begin
      b0[i] = 8'($urandom);
      src0.push_back({i == len0 - 1, b0[i]});
    end
    for (int i = 0; i < len1; i++) begin
      b1[i] = 8'($urandom);
      src1.push_back({i == len1 - 1, b1[i]});
    end
    if (len0 == len1) begin
      for (int i = 0; i < n; i++)
        expq.push_back({i == n - 1, b1[i], b0[i]});
    end else begin
      for (int i = 0; i < n - 1; i++)
        expq.push_back({1'b0, b1[i], b0[i]});
      mis_total++;
    end
  endtask

  task automatic run_traffic(input int budget, input bit full_rdy);
    logic [1:0]  tv;
    logic [1:0]  hs;
    logic [16:0] e;
    int cyc;
    tv = '0;
    cyc = 0;
    nout = 0;
    while ((src0.size() + src1.size() + expq.size()) > 0
           && cyc < budget) begin
      @(negedge clk);
      if (!tv[0] && src0.size() > 0 && $urandom_range(7) != 0)
        tv[0] = 1'b1;
      if (!tv[1] && src1.size() > 0 && $urandom_range(7) != 0)
        tv[1] = 1'b1;
      i_tvalid = tv;
      i_tdata[7:0]  = tv[0] ? src0[0][7:0] : 8'h00;
      i_tdata[15:8] = tv[1] ? src1[0][7:0] : 8'h00;
      i_tlast[0]    = tv[0] ? src0[0][8] : 1'b0;
      i_tlast[1]    = tv[1] ? src1[0][8] : 1'b0;
      o_tready[0] = full_rdy || ($urandom_range(3) != 0);
      o_tready[1] = full_rdy || ($urandom_range(3) != 0);
      #1;
      chk("tdata_pass", 32'(o_tdata), 32'(i_tdata));
      chk("ovalid_sync", 32'(o_tvalid[1]), 32'(o_tvalid[0]));
      if (o_tvalid[0]) begin
        chk("ovalid_rdy", 32'(o_tready), 32'd3);
        if (expq.size() == 0) begin
          chk("extra_beat", 32'(expq.size()), 32'd1);
        end else begin
          e = expq.pop_front();
          nout++;
          chk("out_beat", 32'({o_tlast[0], o_tdata}), 32'(e));
        end
      end
      hs = i_tvalid & i_tready;
      if (hs[0]) begin
        void'(src0.pop_front());
        tv[0] = 1'b0;
      end
      if (hs[1]) begin
        void'(src1.pop_front());
        tv[1] = 1'b0;
      end
      cyc++;
    end
    chk("drain", 32'(src0.size() + src1.size() + expq.size()), 32'd0);
    @(negedge clk);
    i_tvalid = '0;
    i_tlast  = '0;
    @(negedge clk);
    chk("misalign_cnt", 32'(misalign_cnt), exp_cnt());
  endtask

  task automatic pulse(input bit use_clear);
    @(negedge clk);
    if (use_clear) clear = 1'b1;
    else reset = 1'b1;
    i_tvalid = 2'b11;
    i_tlast  = 2'b00;
    o_tready = 2'b11;
    #1;
    chk("rst_itready", 32'(i_tready), 32'd0);
    chk("rst_ovalid", 32'(o_tvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear = 1'b0;
    i_tvalid = '0;
    mis_total = 0;
    #1;
    chk("rst_cnt", 32'(misalign_cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    // Reset, with all inputs active during the reset cycle.
    pulse(1'b0);

    // Two aligned 4-beat packets, downstream always ready.
    add_pair(4, 4);
    run_traffic(200, 1'b1);
    chk("beats_aligned", 32'(nout), 32'd4);

    // 3-beat vs 4-beat, then aligned 2-beat packets.
    add_pair(3, 4);
    add_pair(2, 2);
    run_traffic(200, 1'b1);
    chk("beats_misalign", 32'(nout), 32'd4);

    // Partial downstream readiness: nothing moves.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_tvalid = 2'b11;
      i_tlast  = 2'b00;
      o_tready = 2'b01;
      #1;
      chk("bp_ovalid", 32'(o_tvalid), 32'd0);
      chk("bp_itready", 32'(i_tready), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_stall", 32'(stall), 32'd0);
    end
    @(negedge clk);
    i_tvalid = '0;

    // Watchdog: only port 0 valid for 20 cycles.
    pulse(1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      i_tvalid = 2'b01;
      i_tlast  = 2'b00;
      o_tready = 2'b11;
      @(posedge clk);
      #1;
      chk("wd_stall", 32'(stall), 32'(WD_ON && k >= TO));
    end
    @(negedge clk);
    i_tvalid = 2'b11;
    i_tlast  = 2'b11;
    @(posedge clk);
    #1;
    chk("wd_held", 32'(stall), 32'(WD_ON));
    pulse(1'b1);

    // Randomized packet pairs with random valid/ready gaps.
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 4; p++) begin
        int l0;
        int l1;
        l0 = $urandom_range(1, 5);
        l1 = ($urandom_range(1) != 0) ? l0 : $urandom_range(1, 5);
        add_pair(l0, l1);
      end
      run_traffic(2000, 1'b0);
    end

    // Counter saturation: 19 misalignments from a clean start.
    pulse(1'b1);
    for (int p = 0; p < 19; p++) add_pair(1, 2);
    add_pair(2, 2);
    run_traffic(4000, 1'b0);
    chk("sat_cnt", 32'(misalign_cnt), 32'd15);

    // Reset in the middle of a flush.
    @(negedge clk);
    i_tvalid = 2'b11;
    i_tlast  = 2'b01;
    o_tready = 2'b11;
    #1;
    chk("mis_ovalid", 32'(o_tvalid), 32'd0);
    chk("mis_itready", 32'(i_tready), 32'd0);
    @(negedge clk);
    #1;
    chk("flush_rdy0", 32'(i_tready), 32'd3);
    chk("flush_ovalid", 32'(o_tvalid), 32'd0);
    @(negedge clk);
    #1;
    chk("flush_rdy1", 32'(i_tready), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(i_tready), 32'd0);
    chk("mid_rst_ov", 32'(o_tvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    i_tlast = 2'b11;
    mis_total = 0;
    #1;
    chk("run_after_rst", 32'(o_tvalid), 32'd3);
    chk("cnt_after_rst", 32'(misalign_cnt), exp_cnt());
    @(negedge clk);
    i_tvalid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sync_ctrl.md
AXI_SYNC_CTRL -- requirements
Module: axi_sync_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE, default 2, number of synchronized ports.
REQ-002 The block SHALL have parameter WIDTH, default 32, tdata bits per port (equal on all ports).
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, stall-watchdog threshold in cycles (>=2).
REQ-004 The block SHALL have parameter CNT_W, default 16, misalignment counter width.
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clear  input  1  synchronous, active-high soft clear; same effect as reset.
REQ-008 i_tdata  input  SIZE*WIDTH  per-port input data; port k at [k*WIDTH +: WIDTH].
REQ-009 i_tlast / i_tvalid  input  SIZE  per-port input framing and valid.
REQ-010 i_tready  output  SIZE  per-port input ready.
REQ-011 o_tdata  output  SIZE*WIDTH  per-port output data, same packing as i_tdata.
REQ-012 o_tlast / o_tvalid  output  SIZE  per-port output framing and valid.
REQ-013 o_tready  input  SIZE  per-port output ready.
REQ-014 misalign_cnt  output  CNT_W  saturating count of detected packet misalignments.
REQ-015 stall  output  1  sticky watchdog flag: partial-valid stall exceeded TIMEOUT.

Function
REQ-016 FSM states SHALL be RUN and FLUSH.
REQ-017 o_tdata/o_tlast SHALL pass i_tdata/i_tlast combinationally, zero latency, no storage.
REQ-018 In RUN, define all_v = &i_tvalid, all_r = &o_tready, match = (i_tlast all 0 or all 1).
REQ-019 In RUN, release = all_v & all_r & match; o_tvalid and i_tready SHALL equal {SIZE{release}}.
REQ-020 In RUN, all_v & ~match SHALL: output nothing, increment misalign_cnt (saturate at 2^CNT_W-1), enter FLUSH next cycle; independent of o_tready.
REQ-021 On FLUSH entry, per-port done flags SHALL clear to 0.
REQ-022 In FLUSH, o_tvalid SHALL be 0; i_tready[k] SHALL equal ~done[k]; every accepted beat is discarded.
REQ-023 In FLUSH, done[k] SHALL set on the cycle after port k accepts a beat with i_tlast=1.
REQ-024 FSM SHALL return FLUSH->RUN the cycle after all done flags are 1 (including same-cycle final tlasts).
REQ-025 Watchdog counter SHALL increment in RUN while |i_tvalid & ~all_v, else reset to 0.
REQ-026 When watchdog counter reaches TIMEOUT, stall SHALL set and remain set until reset/clear.
REQ-027 Watchdog SHALL NOT count in FLUSH nor while all_v & ~all_r (downstream backpressure).
REQ-028 SIZE=1 SHALL degenerate to pass-through: match always true, FLUSH unreachable.

Reset
REQ-029 Reset or clear SHALL force RUN, done=0, misalign_cnt=0, watchdog=0, stall=0.
REQ-030 Reset/clear mid-FLUSH SHALL abandon flush; next cycle operates as RUN.
REQ-031 During the reset/clear cycle, i_tready and o_tvalid SHALL be 0.

Configuration
REQ-032 Macro AXI_SYNC_CTRL_WATCHDOG_EN SHALL gate the stall watchdog.
REQ-033 With AXI_SYNC_CTRL_WATCHDOG_EN defined, REQ-025..REQ-027 apply.
REQ-034 Without it, watchdog logic SHALL be absent and stall tied to 0; all else unchanged.

Verification
REQ-035 SIZE=2, both ports send 4-beat packets aligned, o_tready=1 -> 8 beats out, o_tvalid coincident on both, misalign_cnt=0.
REQ-036 Port0 3-beat pkt, port1 4-beat pkt, then aligned 2-beat pkts -> misalign_cnt=1, residual beats of both dropped, next 2-beat pkts emitted aligned.
REQ-037 All valid, o_tready=2'b01 for 10 cycles -> no transfer on either port, o_tvalid=0, stall=0.
REQ-038 Watchdog enabled, TIMEOUT=16, only port0 valid for 20 cycles -> stall=1 at cycle 16, held after port1 arrives; clear -> stall=0.
REQ-039 Force 2^CNT_W+3 misalignments with CNT_W=4 -> misalign_cnt saturates at 15; reset mid-FLUSH -> RUN next cycle, counter 0.
